hamming_count_sched: RTL and testbench
======================================

# hamming_count_sched

Sequencer for the Hamming-protected counter datapath (`counter_and_parity` + `syndrome`). It queues increment requests from a client and drives the datapath `enable` in bounded bursts. After every burst it inserts an encode cycle and a check window, and periodically opens scrub windows while idle. It also accumulates error and consistency statistics for software. It sits between the client request interface and the datapath `enable` pin in `top`.

## Interface
- `WIDTH`, 4: counter width; must match the datapath.
- `PEND_W`, 4: width of the pending-increment credit counter; capacity is 2^PEND_W-1.
- `MAX_BURST`, 8: maximum consecutive COUNT cycles before a forced ENCODE; range 1..2^PEND_W-1.
- `CHECK_CYCLES`, 3: length of the check window; minimum 2.
- `SCRUB_PERIOD`, 64: number of idle cycles between scrub windows; minimum 2.
- `ERR_W`, 8: width of the error statistics counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inc_valid` in 1: increment request; one request per cycle.
- `inc_ready` out 1: high when the credit counter is not full.
- `clr_stat` in 1: synchronous clear of `err_count`, `overflow` and `mismatch`.
- `dp_enable` out 1: drives the datapath `enable`.
- `dp_error` in 1: datapath `error_detected`.
- `dp_counter` in WIDTH: datapath `counter`.
- `pending` out PEND_W: current credit count.
- `phase` out 2: FSM state encoding. IDLE=0, COUNT=1, ENCODE=2, CHECK=3.
- `scrub_done` out 1: one-cycle pulse when a check window closes.
- `err_count` out ERR_W: number of check windows that saw `dp_error`; saturating.
- `overflow` out 1: sticky flag; a request arrived while the credit counter was full.
- `mismatch` out 1: sticky flag; `dp_counter` differed from the shadow count at the end of a check window.

## Operation
- Credit counter:
  - `acc` = `inc_valid && inc_ready`; `con` = (`phase`==COUNT).
  - `pending` next value = `pending + acc - con`. Accept and consume in the same cycle leave it unchanged.
  - `inc_valid` while full: request dropped, `overflow` set.
- Shadow counter: WIDTH bits, increments on every COUNT cycle, wraps modulo 2^WIDTH.
- FSM:
  - **IDLE**: `dp_enable`=0.
    - If `pending`≠0: go to COUNT, clear scrub timer.
    - Otherwise the scrub timer increments; at SCRUB_PERIOD-1 go to CHECK and clear the timer.
  - **COUNT**: `dp_enable`=1. Burst counter increments. Go to ENCODE when the next `pending` value is 0 or the burst counter reaches MAX_BURST-1.
  - **ENCODE**: `dp_enable`=0 for exactly one cycle, during which the datapath captures parity. Clear burst counter. Go to CHECK.
  - **CHECK**: `dp_enable`=0 for CHECK_CYCLES cycles.
    - Any cycle with `dp_error`=1 marks the window; a marked window increments `err_count` exactly once.
    - On the last cycle: pulse `scrub_done`, compare `dp_counter` with the shadow counter and set `mismatch` on inequality.
    - Then go to COUNT if `pending`≠0, otherwise IDLE.
- `clr_stat` takes priority over a same-cycle increment or set of `err_count`, `overflow` or `mismatch`.
- `err_count` holds at all-ones once saturated.

## Timing
- Reset values:
  - `phase`=IDLE.
  - `dp_enable`=0, `inc_ready`=1.
  - `pending`, `err_count`, `overflow`, `mismatch` and `scrub_done` all 0.
  - Shadow counter, scrub timer and burst counter all 0.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs except `inc_ready`, which is decoded from `pending` only.
- Request latency: a request accepted in cycle t from IDLE with `pending`=0 gives `pending`=1 at t+1 and `dp_enable`=1 at t+2.
- Burst-to-idle overhead is 1+CHECK_CYCLES cycles. `dp_enable` never stays high for more than MAX_BURST consecutive cycles.
- Requests are accepted in every phase; they are only ever blocked by a full credit counter.
- Asserting `rst` mid-burst forces `dp_enable` low asynchronously. All in-flight credits are lost.

## Structure
- Package `hamming_sched_pkg`:
  - `phase_t` enum (IDLE/COUNT/ENCODE/CHECK, values above).
  - Default parameter constants.
  - Function `sat_inc` for the saturating statistics counter.
- Sub-module `ham_credit_cnt`: the PEND_W-bit up/down credit counter with full detection and overflow flag.
- FSM, timers, shadow counter and statistics live in the top module.

## Test plan
- Reset, then 3 back-to-back `inc_valid` pulses → `dp_enable` high for 3 cycles, then 1 ENCODE cycle and 3 CHECK cycles; `scrub_done` pulses once; shadow = `dp_counter` = 3; `mismatch`=0.
- `inc_valid` held for 20 cycles with MAX_BURST=8 → bursts of 8, 8 and 4 COUNT cycles, each followed by ENCODE+CHECK; final `dp_counter`=20 mod 16=4; `overflow`=0.
- Stall COUNT by holding `inc_valid` with PEND_W=2 → after 3 credits accumulate, `inc_ready`=0 and the next request sets `overflow`; `clr_stat` then clears it.
- No requests for 64 cycles → CHECK entered at cycle 64; force `dp_error`=1 in the 2nd CHECK cycle → `err_count`=1, incremented once only.
- Force `dp_counter`=5 when shadow=4 at the end of CHECK → `mismatch`=1. With ERR_W=2, four erroring windows → `err_count` holds at 3.
- Assert `rst` mid-COUNT → `dp_enable`=0 immediately; after release, `phase`=IDLE, `pending`=0 and all statistics are 0.

Source files
------------

// File: rtl/hamming_sched_pkg.sv
// rtl/hamming_sched_pkg.sv - shared types, defaults and helpers for the Hamming counter sequencer
package hamming_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      ENCODE = 2'd2,
      CHECK  = 2'd3
   } phase_t;

   localparam int DEF_WIDTH        = 4;
   localparam int DEF_PEND_W       = 4;
   localparam int DEF_MAX_BURST    = 8;
   localparam int DEF_CHECK_CYCLES = 3;
   localparam int DEF_SCRUB_PERIOD = 64;
   localparam int DEF_ERR_W        = 8;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_v) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/hamming_count_sched_if.sv
// rtl/hamming_count_sched_if.sv - client request and datapath bundle for the sequencer
interface hamming_count_sched_if #(
   parameter int WIDTH  = 4,
   parameter int PEND_W = 4,
   parameter int ERR_W  = 8
);
   logic              inc_valid;
   logic              inc_ready;
   logic              clr_stat;
   logic              dp_enable;
   logic              dp_error;
   logic [WIDTH-1:0]  dp_counter;
   logic [PEND_W-1:0] pending;
   logic [1:0]        phase;
   logic              scrub_done;
   logic [ERR_W-1:0]  err_count;
   logic              overflow;
   logic              mismatch;

   // Client / datapath side.
   modport master (
      output inc_valid, clr_stat, dp_error, dp_counter,
      input  inc_ready, dp_enable, pending, phase, scrub_done, err_count, overflow, mismatch
   );

   // Sequencer side.
   modport slave (
      input  inc_valid, clr_stat, dp_error, dp_counter,
      output inc_ready, dp_enable, pending, phase, scrub_done, err_count, overflow, mismatch
   );
endinterface

// File: rtl/ham_credit_cnt.sv
// rtl/ham_credit_cnt.sv - up/down pending-increment credit counter with full and overflow
module ham_credit_cnt #(
   parameter int PEND_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              consume_i,
   input  logic              clr_i,
   output logic              ready_o,
   output logic              overflow_o,
   output logic [PEND_W-1:0] pending_o,
   output logic [PEND_W-1:0] pending_next_o
);
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              overflow_q, overflow_d;
   logic              full;
   logic              acc;

   // Next credit count and sticky overflow; clear beats a same-cycle set.
   always_comb begin
      full       = &pending_q;
      acc        = valid_i & ~full;
      pending_d  = pending_q;
      if (acc && !consume_i) begin
         pending_d = pending_q + PEND_W'(1);
      end else if (!acc && consume_i) begin
         pending_d = pending_q - PEND_W'(1);
      end
      overflow_d = overflow_q;
      if (clr_i) begin
         overflow_d = 1'b0;
      end else if (valid_i && full) begin
         overflow_d = 1'b1;
      end
   end

   // Credit and overflow registers; reset drops all in-flight credits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign ready_o        = ~full;
   assign overflow_o     = overflow_q;
   assign pending_o      = pending_q;
   assign pending_next_o = pending_d;
endmodule

// File: rtl/hamming_count_sched.sv
// rtl/hamming_count_sched.sv - burst/encode/check sequencer for the Hamming counter datapath
module hamming_count_sched
   import hamming_sched_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int PEND_W       = DEF_PEND_W,
   parameter int MAX_BURST    = DEF_MAX_BURST,
   parameter int CHECK_CYCLES = DEF_CHECK_CYCLES,
   parameter int SCRUB_PERIOD = DEF_SCRUB_PERIOD,
   parameter int ERR_W        = DEF_ERR_W
) (
   input logic                    clk,
   input logic                    rst,
   hamming_count_sched_if.slave   bus
);
   localparam int SCRUB_W = $clog2(SCRUB_PERIOD);
   localparam int CHK_W   = $clog2(CHECK_CYCLES);

   phase_t             phase_q;
   logic               dp_enable_q;
   logic [PEND_W-1:0]  burst_q;
   logic [SCRUB_W-1:0] scrub_q;
   logic [CHK_W-1:0]   chk_q;
   logic [WIDTH-1:0]   shadow_q;
   logic [ERR_W-1:0]   err_q;
   logic               mark_q;
   logic               mismatch_q;

   logic [PEND_W-1:0]  pending;
   logic [PEND_W-1:0]  pending_next;
   logic               inc_ready;
   logic               overflow;
   logic               last_chk;

   ham_credit_cnt #(.PEND_W(PEND_W)) u_credit (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (bus.inc_valid),
      .consume_i      (phase_q == COUNT),
      .clr_i          (bus.clr_stat),
      .ready_o        (inc_ready),
      .overflow_o     (overflow),
      .pending_o      (pending),
      .pending_next_o (pending_next)
   );

   assign last_chk = (phase_q == CHECK) && (chk_q == CHK_W'(CHECK_CYCLES - 1));

   // Phase sequencing, burst/scrub/check timers, shadow count and statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q     <= IDLE;
         dp_enable_q <= 1'b0;
         burst_q     <= '0;
         scrub_q     <= '0;
         chk_q       <= '0;
         shadow_q    <= '0;
         err_q       <= '0;
         mark_q      <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         case (phase_q)
            IDLE: begin
               if (pending != '0) begin
                  phase_q     <= COUNT;
                  dp_enable_q <= 1'b1;
                  scrub_q     <= '0;
               end else if (scrub_q == SCRUB_W'(SCRUB_PERIOD - 1)) begin
                  phase_q <= CHECK;
                  scrub_q <= '0;
                  chk_q   <= '0;
                  mark_q  <= 1'b0;
               end else begin
                  scrub_q <= scrub_q + 1'b1;
               end
            end
            COUNT: begin
               shadow_q <= shadow_q + 1'b1;
               burst_q  <= burst_q + 1'b1;
               if (pending_next == '0 || burst_q == PEND_W'(MAX_BURST - 1)) begin
                  phase_q     <= ENCODE;
                  dp_enable_q <= 1'b0;
               end
            end
            ENCODE: begin
               burst_q <= '0;
               chk_q   <= '0;
               mark_q  <= 1'b0;
               phase_q <= CHECK;
            end
            CHECK: begin
               chk_q <= chk_q + 1'b1;
               if (bus.dp_error) begin
                  mark_q <= 1'b1;
               end
               if (last_chk) begin
                  mark_q      <= 1'b0;
                  phase_q     <= (pending != '0) ? COUNT : IDLE;
                  dp_enable_q <= (pending != '0);
               end
            end
            default: begin
               phase_q     <= IDLE;
               dp_enable_q <= 1'b0;
            end
         endcase

         if (bus.clr_stat) begin
            err_q      <= '0;
            mismatch_q <= 1'b0;
         end else if (last_chk) begin
            if (mark_q || bus.dp_error) begin
               err_q <= ERR_W'(sat_inc(32'(err_q), ERR_W));
            end
            if (bus.dp_counter != shadow_q) begin
               mismatch_q <= 1'b1;
            end
         end
      end
   end

   assign bus.inc_ready  = inc_ready;
   assign bus.dp_enable  = dp_enable_q;
   assign bus.pending    = pending;
   assign bus.phase      = phase_q;
   assign bus.scrub_done = last_chk;
   assign bus.err_count  = err_q;
   assign bus.overflow   = overflow;
   assign bus.mismatch   = mismatch_q;
endmodule

// File: tb/tb_hamming_count_sched.sv
// tb/tb_hamming_count_sched.sv - directed self-checking bench for hamming_count_sched
module tb_hamming_count_sched;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   logic [3:0] dp_model;
   logic [3:0] sdp_model;
   logic       force_en;
   logic [3:0] force_val;

   hamming_count_sched_if #(.WIDTH(4), .PEND_W(4), .ERR_W(8)) bus ();
   hamming_count_sched_if #(.WIDTH(4), .PEND_W(2), .ERR_W(2)) sbus ();

   hamming_count_sched u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   hamming_count_sched #(.PEND_W(2), .MAX_BURST(3), .ERR_W(2)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stand-ins: count every enabled cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) dp_model <= 4'd0;
      else if (bus.dp_enable) dp_model <= dp_model + 4'd1;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) sdp_model <= 4'd0;
      else if (sbus.dp_enable) sdp_model <= sdp_model + 4'd1;
   end

   assign bus.dp_counter  = force_en ? force_val : dp_model;
   assign sbus.dp_counter = sdp_model;

   task automatic do_reset();
      rst = 1'b0;
      bus.inc_valid = 1'b0; bus.clr_stat = 1'b0; bus.dp_error = 1'b0;
      sbus.inc_valid = 1'b0; sbus.clr_stat = 1'b0; sbus.dp_error = 1'b0;
      force_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
      checks++; if (bus.dp_enable !== 1'b0) begin errors++; $display("FAIL reset_dp_enable got=%b exp=0", bus.dp_enable); end
      checks++; if (bus.inc_ready !== 1'b1) begin errors++; $display("FAIL reset_inc_ready got=%b exp=1", bus.inc_ready); end
      checks++; if (bus.pending !== 4'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", bus.pending); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", bus.err_count); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
      checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got=%b exp=0", bus.mismatch); end
      checks++; if (bus.scrub_done !== 1'b0) begin errors++; $display("FAIL reset_scrub_done got=%b exp=0", bus.scrub_done); end
      rst = 1'b1;
   endtask

   task automatic test_single_burst();
      logic [1:0] exp_ph [1:10];
      int pulses;
      exp_ph = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
      pulses = 0;
      do_reset();
      bus.inc_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 3) bus.inc_valid = 1'b0;
         checks++; if (bus.phase !== exp_ph[k]) begin errors++; $display("FAIL single_phase[%0d] got=%0d exp=%0d", k, bus.phase, exp_ph[k]); end
         checks++; if (bus.dp_enable !== (exp_ph[k] == 2'd1)) begin errors++; $display("FAIL single_dp_enable[%0d] got=%b exp=%b", k, bus.dp_enable, exp_ph[k] == 2'd1); end
         if (k == 2) begin
            checks++; if (bus.pending !== 4'd2) begin errors++; $display("FAIL single_pending got=%0d exp=2", bus.pending); end
         end
         if (bus.scrub_done === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL single_scrub_pulses got=%0d exp=1", pulses); end
      checks++; if (bus.dp_counter !== 4'd3) begin errors++; $display("FAIL single_dp_counter got=%0d exp=3", bus.dp_counter); end
      checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL single_mismatch got=%b exp=0", bus.mismatch); end
   endtask

   task automatic test_long_burst();
      int runs [4];
      int nruns;
      int cur;
      int encs;
      nruns = 0; cur = 0; encs = 0;
      runs = '{0, 0, 0, 0};
      do_reset();
      for (int k = 0; k < 45; k++) begin
         bus.inc_valid = (k < 20);
         @(negedge clk);
         if (bus.dp_enable === 1'b1) begin
            cur++;
         end else if (cur > 0) begin
            if (nruns < 4) runs[nruns] = cur;
            nruns++;
            cur = 0;
         end
         if (bus.phase === 2'd2) encs++;
      end
      bus.inc_valid = 1'b0;
      checks++; if (nruns != 3) begin errors++; $display("FAIL long_nbursts got=%0d exp=3", nruns); end
      checks++; if (runs[0] != 8) begin errors++; $display("FAIL long_burst0 got=%0d exp=8", runs[0]); end
      checks++; if (runs[1] != 8) begin errors++; $display("FAIL long_burst1 got=%0d exp=8", runs[1]); end
      checks++; if (runs[2] != 4) begin errors++; $display("FAIL long_burst2 got=%0d exp=4", runs[2]); end
      checks++; if (encs != 3) begin errors++; $display("FAIL long_encodes got=%0d exp=3", encs); end
      checks++; if (bus.dp_counter !== 4'd4) begin errors++; $display("FAIL long_dp_counter got=%0d exp=4", bus.dp_counter); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL long_overflow got=%b exp=0", bus.overflow); end
      checks++; if (bus.pending !== 4'd0) begin errors++; $display("FAIL long_pending got=%0d exp=0", bus.pending); end
   endtask

   task automatic test_overflow();
      logic found;
      found = 1'b0;
      do_reset();
      sbus.inc_valid = 1'b1;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (sbus.inc_ready === 1'b0) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL ovf_full_timeout got=ready exp=not_ready"); end
      checks++; if (sbus.pending !== 2'd3) begin errors++; $display("FAIL ovf_pending got=%0d exp=3", sbus.pending); end
      checks++; if (sbus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", sbus.overflow); end
      @(negedge clk);
      checks++; if (sbus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", sbus.overflow); end
      sbus.inc_valid = 1'b0;
      sbus.clr_stat = 1'b1;
      @(negedge clk);
      sbus.clr_stat = 1'b0;
      checks++; if (sbus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", sbus.overflow); end
   endtask

   task automatic test_scrub_error();
      logic found;
      int   n;
      found = 1'b0; n = 0;
      do_reset();
      for (int k = 1; k <= 100 && !found; k++) begin
         @(negedge clk);
         if (bus.phase === 2'd3) begin found = 1'b1; n = k; end
      end
      checks++; if (!found || n != 64) begin errors++; $display("FAIL scrub_entry got=%0d exp=64", n); end
      @(negedge clk);
      bus.dp_error = 1'b1;
      @(negedge clk);
      checks++; if (bus.scrub_done !== 1'b1) begin errors++; $display("FAIL scrub_done got=%b exp=1", bus.scrub_done); end
      @(negedge clk);
      bus.dp_error = 1'b0;
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL scrub_err_count got=%0d exp=1", bus.err_count); end
      checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL scrub_exit_phase got=%0d exp=0", bus.phase); end
      repeat (5) @(negedge clk);
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL scrub_err_once got=%0d exp=1", bus.err_count); end
   endtask

   task automatic test_saturate();
      logic       found;
      logic [1:0] exp_err;
      do_reset();
      sbus.dp_error = 1'b1;
      for (int w = 0; w < 4; w++) begin
         sbus.inc_valid = 1'b1;
         @(negedge clk);
         sbus.inc_valid = 1'b0;
         found = 1'b0;
         for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (sbus.scrub_done === 1'b1) found = 1'b1;
         end
         checks++; if (!found) begin errors++; $display("FAIL sat_window%0d_timeout got=none exp=scrub_done", w); end
         @(negedge clk);
         exp_err = (w < 3) ? 2'(w + 1) : 2'd3;
         checks++; if (sbus.err_count !== exp_err) begin errors++; $display("FAIL sat_err_count[%0d] got=%0d exp=%0d", w, sbus.err_count, exp_err); end
      end
      sbus.dp_error = 1'b0;
   endtask

   task automatic test_mismatch();
      logic found;
      do_reset();
      bus.inc_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.inc_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (bus.phase === 2'd2) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL mm_encode_timeout got=none exp=ENCODE"); end
      force_val = 4'd5;
      force_en = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (bus.scrub_done === 1'b1) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL mm_window_timeout got=none exp=scrub_done"); end
      @(negedge clk);
      force_en = 1'b0;
      checks++; if (bus.mismatch !== 1'b1) begin errors++; $display("FAIL mm_set got=%b exp=1", bus.mismatch); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL mm_err_count got=%0d exp=0", bus.err_count); end
      bus.clr_stat = 1'b1;
      @(negedge clk);
      bus.clr_stat = 1'b0;
      checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL mm_clear got=%b exp=0", bus.mismatch); end
   endtask

   task automatic test_async_reset();
      logic found;
      found = 1'b0;
      bus.inc_valid = 1'b1;
      bus.dp_error = 1'b1;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         if (bus.err_count === 8'd1 && bus.phase === 2'd1) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL arst_setup_timeout got=none exp=COUNT_with_err"); end
      #1 rst = 1'b0;
      #1;
      checks++; if (bus.dp_enable !== 1'b0) begin errors++; $display("FAIL arst_dp_enable got=%b exp=0", bus.dp_enable); end
      checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL arst_phase got=%0d exp=0", bus.phase); end
      bus.inc_valid = 1'b0;
      bus.dp_error = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++; if (bus.pending !== 4'd0) begin errors++; $display("FAIL arst_pending got=%0d exp=0", bus.pending); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL arst_err_count got=%0d exp=0", bus.err_count); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow got=%b exp=0", bus.overflow); end
      checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL arst_mismatch got=%b exp=0", bus.mismatch); end
      checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL arst_phase_after got=%0d exp=0", bus.phase); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      force_en = 1'b0;
      force_val = 4'd0;
      bus.inc_valid = 1'b0; bus.clr_stat = 1'b0; bus.dp_error = 1'b0;
      sbus.inc_valid = 1'b0; sbus.clr_stat = 1'b0; sbus.dp_error = 1'b0;
      test_reset();
      test_single_burst();
      test_long_burst();
      test_overflow();
      test_scrub_error();
      test_saturate();
      test_mismatch();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
